// File: rtl/triangle_dispatcher_if.sv
// Handshake bundle between the triangle source, the dispatcher and the rasterizer.
// The slave modport is the dispatcher's view; master is the environment driving it.
interface triangle_dispatcher_if;
  logic             in_valid;
  logic             in_ready;
  logic [59:0]      in_tri;
  logic             ru_start;
  logic [2:0][31:0] ru_p1;
  logic [2:0][31:0] ru_p2;
  logic [2:0][31:0] ru_p3;
  logic             ru_done;

  modport master (
    output in_valid, in_tri, ru_done,
    input  in_ready, ru_start, ru_p1, ru_p2, ru_p3
  );

  modport slave (
    input  in_valid, in_tri, ru_done,
    output in_ready, ru_start, ru_p1, ru_p2, ru_p3
  );
endinterface

// File: rtl/triangle_dispatcher.sv
// Buffers integer-vertex triangles in a FIFO and hands them one at a time to the
// rasterizer as float vertices, holding the FIFO head until the rasterizer reports done.
module triangle_dispatcher #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 areset_n,
  triangle_dispatcher_if.slave bus,
  output logic                 busy,
  output logic [15:0]          tri_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;
  localparam logic [31:0] FloatOne = 32'h3F80_0000;

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  state_e           state_q, state_d;
  logic [59:0]      mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0][31:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [15:0]      tri_count_q, tri_count_d;
  logic             empty, full, push, pop, load;
  logic [59:0]      head;

  // Exact for any 10-bit value: all significant bits fit in the 23-bit mantissa.
  function automatic logic [31:0] to_float(input logic [9:0] v);
    logic [3:0]  k;
    logic [4:0]  sh;
    logic [22:0] mant;
    logic [31:0] f;
    k = '0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) k = 4'(i);
    end
    sh   = 5'd23 - {1'b0, k};
    mant = {13'd0, v} << sh;
    if (v == '0) f = '0;
    else         f = {1'b0, 8'd127 + {4'd0, k}, mant};
    return f;
  endfunction

  function automatic logic [2:0][31:0] to_vertex(input logic [9:0] x, input logic [9:0] y);
    return {FloatOne, to_float(y), to_float(x)};
  endfunction

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign push  = bus.in_valid && !full;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StStart;
          load    = 1'b1;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (bus.ru_done) begin
          state_d = StIdle;
          pop     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    tri_count_d = pop ? tri_count_q + 16'd1 : tri_count_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    if (load) begin
      p1_d = to_vertex(head[9:0], head[19:10]);
      p2_d = to_vertex(head[29:20], head[39:30]);
      p3_d = to_vertex(head[49:40], head[59:50]);
    end
  end

  // Outputs.
  always_comb begin
    bus.ru_start = (state_q == StStart);
    bus.in_ready = !full;
    bus.ru_p1    = p1_q;
    bus.ru_p2    = p2_q;
    bus.ru_p3    = p3_q;
    busy         = (state_q != StIdle) || !empty;
    tri_count    = tri_count_q;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      tri_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      tri_count_q <= tri_count_d;
    end
  end

  // Storage needs no reset: contents are only read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_tri;
  end

endmodule

// File: doc/triangle_dispatcher.md
TRIANGLE_DISPATCHER -- requirements
Module: triangle_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of triangle entries in the input FIFO (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock, the 150 MHz GPU clock; all logic on its rising edge.
REQ-003 SHALL have port areset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  a triangle is offered on in_tri.
REQ-005 SHALL have port in_ready  output  1  FIFO can accept; a transfer occurs on a cycle with in_valid=1 and in_ready=1.
REQ-006 SHALL have port in_tri  input  60  integer screen vertices packed {y2,x2,y1,x1,y0,x0}, each 10-bit unsigned.
REQ-007 SHALL have port ru_start  output  1  one-cycle start pulse to the rasterizer.
REQ-008 SHALL have ports ru_p1, ru_p2, ru_p3  output  3x32 each  vertex {x,y,z} as IEEE-754 single, element 0=x, 1=y, 2=z.
REQ-009 SHALL have port ru_done  input  1  rasterizer finished the current triangle, sampled as a level.
REQ-010 SHALL have port busy  output  1  high when state is not IDLE or the FIFO is non-empty.
REQ-011 SHALL have port tri_count  output  16  number of triangles completed since reset.

Function
REQ-012 SHALL buffer triangles in a DEPTH-entry FIFO, with in_ready = not full; a full FIFO SHALL NOT use pop-through.
REQ-013 SHALL allow a push and a pop on the same cycle; occupancy SHALL then stay unchanged.
REQ-014 SHALL run an FSM with states IDLE, START and WAIT.
REQ-015 SHALL, in IDLE with the FIFO non-empty, load ru_p1..ru_p3 from the converted FIFO head at the next edge and go to START; with the FIFO empty it SHALL stay in IDLE.
REQ-016 SHALL drive ru_start=1 in START only (Moore output, exactly one cycle) and go to WAIT at the next edge.
REQ-017 SHALL, in WAIT with ru_done=1, pop the FIFO head, increment tri_count and return to IDLE at that edge; otherwise it SHALL stay in WAIT indefinitely (no timeout).
REQ-018 SHALL ignore ru_done in IDLE and START.
REQ-019 SHALL hold ru_p1..ru_p3 stable from the load edge until the next load.
REQ-020 SHALL keep the FIFO head unpopped until done, so the FIFO holds at most DEPTH triangles including the one in flight.
REQ-021 SHALL give latency: handshake at edge E0 with an empty FIFO in IDLE -> registers loaded at E1 -> ru_start high between E1 and E2.
REQ-022 SHALL give a throughput of at most one triangle per (3 + rasterizer busy) cycles; IDLE always lasts at least one cycle between triangles.
REQ-023 SHALL convert each coordinate v to a float with combinational logic: v=0 -> 32'h00000000; otherwise k = index of the MSB set (0..9), sign 0, exponent 127+k, mantissa = (v << (23-k))[22:0]; the result is exact.
REQ-024 SHALL drive the z element of every vertex as the constant 32'h3F800000 (1.0).
REQ-025 SHALL map x0/y0 to ru_p1, x1/y1 to ru_p2 and x2/y2 to ru_p3.
REQ-026 SHALL let tri_count wrap modulo 2^16 (FFFF -> 0000) without flagging.

Reset
REQ-027 SHALL, on areset_n low, immediately: set state IDLE, empty the FIFO (pointers 0), set ru_start=0, set ru_p1..ru_p3 to all zero, set tri_count=0, busy=0, in_ready=1.
REQ-028 SHALL, when reset is asserted mid-triangle in WAIT, discard the in-flight triangle and all queued triangles; a late ru_done after release SHALL be ignored (state IDLE).
REQ-029 SHALL release reset synchronously to clk by an external synchronizer; the block SHALL NOT add one.

Verification
REQ-030 SHALL cover single triangle: push {x0=69,y0=69,x1=69,y1=169,x2=169,y2=69} -> ru_start pulses 2 edges later; ru_p1={428A0000,428A0000,3F800000}, ru_p2={428A0000,43290000,3F800000}, ru_p3={43290000,428A0000,3F800000}; ru_done -> tri_count=1.
REQ-031 SHALL cover conversion corners: coordinates 0, 1, 2, 512, 1023 -> 00000000, 3F800000, 40000000, 44000000, 447FC000.
REQ-032 SHALL cover FIFO full: DEPTH=4, ru_done held low, push 5 triangles -> in_ready=0 after 4; one ru_done -> in_ready=1 and the 5th is accepted, with order preserved.
REQ-033 SHALL cover back-to-back flow: 3 queued triangles with ru_done returned 10 cycles after each start -> exactly 3 ru_start pulses, each 1 cycle wide, ru_p1..ru_p3 never change during WAIT, tri_count=3, busy falls after the last done.
REQ-034 SHALL cover reset mid-operation: areset_n low in WAIT with 2 queued -> outputs per REQ-027 immediately; ru_done after release -> tri_count stays 0, no ru_start.
REQ-035 SHALL cover wrap and simultaneous events: tri_count at FFFF plus a done -> 0000; a push on the same cycle as a pop with a full FIFO -> push refused (in_ready was 0).
